// File: rtl/cascade_sequencer.sv
// cascade_sequencer: 8259A cascade controller that tracks the INTA pulse train and arbitrates the data bus.
// Build option CASCADE_TIMEOUT_EN adds an inter-pulse timeout that aborts a stalled sequence.
module cascade_sequencer #(
    parameter int CAS_WIDTH   = 3,
    parameter int NUM_IR      = 8,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 single_or_cascade_config,
    input  logic                 mode_8086_config,
    input  logic                 buffered_mode_config,
    input  logic                 buffered_master_or_slave_config,
    input  logic                 slave_program_n,
    input  logic [NUM_IR-1:0]    cascade_device_config,
    input  logic                 interrupt_acknowledge_n,
    input  logic [CAS_WIDTH-1:0] acknowledge_ir,
    input  logic [CAS_WIDTH-1:0] cascade_in,
    output logic [CAS_WIDTH-1:0] cascade_out,
    output logic                 cascade_io,
    output logic                 cascade_slave,
    output logic                 cascade_slave_enable,
    output logic                 interrupt_from_slave_device,
    output logic                 output_vector_enable,
    output logic                 buffer_enable,
    output logic [1:0]           ack_pulse_index,
    output logic                 ack_done,
    output logic                 ack_abort,
    output logic [2:0]           fsm_state
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        P1   = 3'd1,
        G1   = 3'd2,
        P2   = 3'd3,
        G2   = 3'd4,
        P3   = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic                  inta_prev_q;
    logic                  single_q, single_d;
    logic                  m8086_q, m8086_d;
    logic                  buf_q, buf_d;
    logic                  slave_q, slave_d;
    logic [CAS_WIDTH-1:0]  ir_q, ir_d;
    logic [NUM_IR-1:0]     cfg_q, cfg_d;
    logic                  cse_q, cse_d;
    logic [CAS_WIDTH-1:0]  cas_out_q, cas_out_d;
    logic                  ifsd_q, ifsd_d;
    logic                  ove_q, ove_d;
    logic                  buf_en_q, buf_en_d;
    logic [1:0]            idx_q, idx_d;
    logic                  done_q, done_d;
    logic                  fall, rise, master, vector_ok;

`ifdef CASCADE_TIMEOUT_EN
    localparam int CNT_W = ($clog2(ACK_TIMEOUT) + 1 > 8) ? $clog2(ACK_TIMEOUT) + 1 : 8;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             abort_q, abort_d;
`endif

    // Role is live from the pins; the sequence itself uses the copy latched at P1 entry.
    assign cascade_slave = ~single_or_cascade_config &
                           (buffered_mode_config ? ~buffered_master_or_slave_config : ~slave_program_n);
    assign cascade_io    = ~single_or_cascade_config & ~cascade_slave;

    always_comb begin
        fall     = inta_prev_q & ~interrupt_acknowledge_n;
        rise     = ~inta_prev_q & interrupt_acknowledge_n;
        state_d  = state_q;
        single_d = single_q;
        m8086_d  = m8086_q;
        buf_d    = buf_q;
        slave_d  = slave_q;
        ir_d     = ir_q;
        cfg_d    = cfg_q;
        cse_d    = cse_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: if (fall) begin
                state_d  = P1;
                single_d = single_or_cascade_config;
                m8086_d  = mode_8086_config;
                buf_d    = buffered_mode_config;
                slave_d  = cascade_slave;
                ir_d     = acknowledge_ir;
                cfg_d    = cascade_device_config;
                cse_d    = 1'b0;
            end
            P1: if (rise) begin
                state_d = G1;
                cse_d   = slave_q & (cascade_in == cfg_q[CAS_WIDTH-1:0]);
            end
            G1: if (fall) state_d = P2;
            P2: if (rise) begin
                if (m8086_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = G2;
                end
            end
            G2: if (fall) state_d = P3;
            P3: if (rise) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase

`ifdef CASCADE_TIMEOUT_EN
        abort_d = 1'b0;
        cnt_d   = '0;
        // A falling edge on the terminal-count cycle takes priority over the abort.
        if ((state_q == G1 || state_q == G2) && !fall) begin
            if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
                state_d = IDLE;
                abort_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
`endif

        if (state_d == IDLE) cse_d = 1'b0;

        master    = ~slave_d & ~single_d;
        ifsd_d    = (state_d != IDLE) & master & cfg_d[ir_d];
        cas_out_d = ((state_d != IDLE) & master) ? ir_d : '0;
        vector_ok = single_d | (master ? ~ifsd_d : cse_d);
        ove_d     = 1'b0;
        idx_d     = 2'd0;
        case (state_d)
            P1: begin
                ove_d = ~m8086_d & ~slave_d;
                idx_d = 2'd1;
            end
            P2: begin
                ove_d = vector_ok;
                idx_d = 2'd2;
            end
            P3: begin
                ove_d = vector_ok;
                idx_d = 2'd3;
            end
            default: begin
                ove_d = 1'b0;
                idx_d = 2'd0;
            end
        endcase
        buf_en_d = buf_d & ove_d;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            inta_prev_q <= 1'b1;
            single_q    <= 1'b0;
            m8086_q     <= 1'b0;
            buf_q       <= 1'b0;
            slave_q     <= 1'b0;
            ir_q        <= '0;
            cfg_q       <= '0;
            cse_q       <= 1'b0;
            cas_out_q   <= '0;
            ifsd_q      <= 1'b0;
            ove_q       <= 1'b0;
            buf_en_q    <= 1'b0;
            idx_q       <= 2'd0;
            done_q      <= 1'b0;
`ifdef CASCADE_TIMEOUT_EN
            cnt_q       <= '0;
            abort_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            inta_prev_q <= interrupt_acknowledge_n;
            single_q    <= single_d;
            m8086_q     <= m8086_d;
            buf_q       <= buf_d;
            slave_q     <= slave_d;
            ir_q        <= ir_d;
            cfg_q       <= cfg_d;
            cse_q       <= cse_d;
            cas_out_q   <= cas_out_d;
            ifsd_q      <= ifsd_d;
            ove_q       <= ove_d;
            buf_en_q    <= buf_en_d;
            idx_q       <= idx_d;
            done_q      <= done_d;
`ifdef CASCADE_TIMEOUT_EN
            cnt_q       <= cnt_d;
            abort_q     <= abort_d;
`endif
        end
    end

    assign cascade_out                 = cas_out_q;
    assign cascade_slave_enable        = cse_q;
    assign interrupt_from_slave_device = ifsd_q;
    assign output_vector_enable        = ove_q;
    assign buffer_enable               = buf_en_q;
    assign ack_pulse_index             = idx_q;
    assign ack_done                    = done_q;
    assign fsm_state                   = state_q;
`ifdef CASCADE_TIMEOUT_EN
    assign ack_abort                   = abort_q;
`else
    assign ack_abort                   = 1'b0;
`endif

endmodule

// File: tb/tb_cascade_sequencer.sv
// Bench for cascade_sequencer: event-level model of the INTA train checked every cycle, plus directed literals.
// Covers both builds; the timeout scenario adapts when CASCADE_TIMEOUT_EN is defined.
module tb_cascade_sequencer;
    localparam int CW = 3;
    localparam int NI = 8;
    localparam int TO = 16;
`ifdef CASCADE_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    // clock / reset
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          reset_n = 1'b0;
    logic          single = 1'b0, m86 = 1'b0, bufm = 1'b0, ms = 1'b0, sp_n = 1'b1;
    logic [NI-1:0] cfg = '0;
    logic          inta_n = 1'b1;
    logic [CW-1:0] ack_ir = '0, cas_in = '0;

    logic [CW-1:0] cascade_out;
    logic          cascade_io, cascade_slave, cascade_slave_enable, interrupt_from_slave_device;
    logic          output_vector_enable, buffer_enable, ack_done, ack_abort;
    logic [1:0]    ack_pulse_index;
    logic [2:0]    fsm_state;

    int n_vec = 0;
    int n_err = 0;

    cascade_sequencer #(.CAS_WIDTH(CW), .NUM_IR(NI), .ACK_TIMEOUT(TO)) dut (
        .clock                           (clock),
        .reset_n                         (reset_n),
        .single_or_cascade_config        (single),
        .mode_8086_config                (m86),
        .buffered_mode_config            (bufm),
        .buffered_master_or_slave_config (ms),
        .slave_program_n                 (sp_n),
        .cascade_device_config           (cfg),
        .interrupt_acknowledge_n         (inta_n),
        .acknowledge_ir                  (ack_ir),
        .cascade_in                      (cas_in),
        .cascade_out                     (cascade_out),
        .cascade_io                      (cascade_io),
        .cascade_slave                   (cascade_slave),
        .cascade_slave_enable            (cascade_slave_enable),
        .interrupt_from_slave_device     (interrupt_from_slave_device),
        .output_vector_enable            (output_vector_enable),
        .buffer_enable                   (buffer_enable),
        .ack_pulse_index                 (ack_pulse_index),
        .ack_done                        (ack_done),
        .ack_abort                       (ack_abort),
        .fsm_state                       (fsm_state)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: counts INTA edges of the current sequence and snapshots the configuration at its start.
    logic          busy = 1'b0, sel = 1'b0, m_prev = 1'b1;
    int            pulses = 0, gap = 0;
    logic          e_done = 1'b0, e_abort = 1'b0;
    logic          s_single = 1'b0, s_m86 = 1'b0, s_buf = 1'b0, s_slave = 1'b0;
    logic [CW-1:0] s_ir = '0;
    logic [NI-1:0] s_cfg = '0;

    always @(posedge clock) begin
        e_done  = 1'b0;
        e_abort = 1'b0;
        if (!reset_n) begin
            busy = 1'b0; sel = 1'b0; pulses = 0; gap = 0; m_prev = 1'b1;
        end else begin
            if (!busy) begin
                if (m_prev && !inta_n) begin
                    busy = 1'b1; pulses = 1; sel = 1'b0; gap = 0;
                    s_single = single; s_m86 = m86; s_buf = bufm;
                    s_slave  = !single && (bufm ? !ms : !sp_n);
                    s_ir = ack_ir; s_cfg = cfg;
                end
            end else if (m_prev && !inta_n) begin
                pulses++;
                gap = 0;
            end else if (!m_prev && inta_n) begin
                if (pulses == 1 && s_slave) sel = (cas_in == s_cfg[CW-1:0]);
                if (pulses == (s_m86 ? 2 : 3)) begin
                    busy = 1'b0;
                    e_done = 1'b1;
                end
                gap = 0;
            end else if (TIMEOUT_ON && inta_n) begin
                gap++;
                if (gap == TO) begin
                    busy = 1'b0;
                    e_abort = 1'b1;
                end
            end
            m_prev = inta_n;
        end
    end

    // Compare process, away from the active edge.
    always @(negedge clock) begin
        logic          master, vok, e_ifsd, e_ove, e_cse, live_slave;
        logic [CW-1:0] e_cas;
        logic [1:0]    e_idx;
        master = !s_slave && !s_single;
        e_ifsd = busy && master && s_cfg[s_ir];
        e_cas  = (busy && master) ? s_ir : '0;
        e_cse  = busy && sel;
        vok    = s_single || (master ? !s_cfg[s_ir] : sel);
        e_idx  = (busy && !m_prev) ? 2'(pulses) : 2'd0;
        e_ove  = 1'b0;
        if (busy && !m_prev) e_ove = (pulses == 1) ? (!s_m86 && !s_slave) : vok;
        live_slave = !single && (bufm ? !ms : !sp_n);
        chk("m.cas_out", 8'(cascade_out), 8'(e_cas));
        chk("m.ifsd", 8'(interrupt_from_slave_device), 8'(e_ifsd));
        chk("m.cse", 8'(cascade_slave_enable), 8'(e_cse));
        chk("m.ove", 8'(output_vector_enable), 8'(e_ove));
        chk("m.buf_en", 8'(buffer_enable), 8'(s_buf && e_ove));
        chk("m.idx", 8'(ack_pulse_index), 8'(e_idx));
        chk("m.done", 8'(ack_done), 8'(e_done));
        chk("m.abort", 8'(ack_abort), 8'(e_abort));
        chk("m.cas_slave", 8'(cascade_slave), 8'(live_slave));
        chk("m.cas_io", 8'(cascade_io), 8'(!single && !live_slave));
    end

    // driver tasks
    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic set_cfg(input logic sg, input logic m8, input logic bf, input logic msv,
                           input logic spn, input logic [NI-1:0] c, input logic [CW-1:0] ir,
                           input logic [CW-1:0] ci);
        single = sg; m86 = m8; bufm = bf; ms = msv; sp_n = spn; cfg = c; ack_ir = ir; cas_in = ci;
        tick();
    endtask

    // Pulses first..last, each low 2 cycles and followed by a 2-cycle gap.
    task automatic do_train(input int first, input int last, input logic [2:0] ove_exp, input string tag);
        for (int k = first; k <= last; k++) begin
            inta_n = 1'b0;
            tick();
            chk({tag, ".idx"}, 8'(ack_pulse_index), 8'(k));
            chk({tag, ".ove"}, 8'(output_vector_enable), 8'(ove_exp[k-1]));
            chk({tag, ".buf"}, 8'(buffer_enable), 8'(bufm & ove_exp[k-1]));
            chk({tag, ".abort"}, 8'(ack_abort), 8'd0);
            tick();
            inta_n = 1'b1;
            tick();
            chk({tag, ".done"}, 8'(ack_done), 8'(k == last));
            chk({tag, ".idx_gap"}, 8'(ack_pulse_index), 8'd0);
            tick();
        end
    endtask

    initial begin
        tick();
        tick();
        chk("rst.idx", 8'(ack_pulse_index), 8'd0);
        chk("rst.cas_out", 8'(cascade_out), 8'd0);
        reset_n = 1'b1;
        tick();

        // master 8086, slave on IR2
        set_cfg(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h04, 3'd2, 3'd0);
        inta_n = 1'b0;
        tick();
        chk("t1.cas_out", 8'(cascade_out), 8'd2);
        chk("t1.ifsd", 8'(interrupt_from_slave_device), 8'd1);
        tick();
        inta_n = 1'b1;
        tick();
        tick();
        do_train(2, 2, 3'b000, "t1");
        chk("t1.idle_cas", 8'(cascade_out), 8'd0);

        // master 8080, no slaves, IR5
        set_cfg(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 3'd5, 3'd0);
        inta_n = 1'b0;
        tick();
        chk("t2.cas_out", 8'(cascade_out), 8'd5);
        chk("t2.ove1", 8'(output_vector_enable), 8'd1);
        tick();
        inta_n = 1'b1;
        tick();
        tick();
        do_train(2, 3, 3'b111, "t2");

        // slave ID 3, 8086: addressed, then not addressed
        set_cfg(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h03, 3'd0, 3'd3);
        chk("t3.slave", 8'(cascade_slave), 8'd1);
        chk("t3.io", 8'(cascade_io), 8'd0);
        do_train(1, 2, 3'b010, "t3a");
        cas_in = 3'd4;
        do_train(1, 2, 3'b000, "t3b");

        // buffered master, 8080, then buffered slave
        set_cfg(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 3'd1, 3'd0);
        do_train(1, 3, 3'b111, "t4");
        set_cfg(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 3'd1, 3'd0);
        chk("t4.bslave_io", 8'(cascade_io), 8'd0);
        chk("t4.bslave", 8'(cascade_slave), 8'd1);

        // single mode, 8080
        set_cfg(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 3'd6, 3'd0);
        do_train(1, 3, 3'b111, "t5");

        // reset during G1, then a fresh sequence
        set_cfg(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 3'd7, 3'd0);
        inta_n = 1'b0;
        tick();
        tick();
        inta_n = 1'b1;
        tick();
        reset_n = 1'b0;
        tick();
        chk("t6.cas_out", 8'(cascade_out), 8'd0);
        chk("t6.ove", 8'(output_vector_enable), 8'd0);
        chk("t6.idx", 8'(ack_pulse_index), 8'd0);
        reset_n = 1'b1;
        tick();
        do_train(1, 3, 3'b111, "t6");

        // inter-pulse timeout: 16 idle gap cycles, then 15 cycles followed by an edge
        set_cfg(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 3'd5, 3'd0);
        inta_n = 1'b0;
        tick();
        tick();
        inta_n = 1'b1;
        tick();
        repeat (TO - 1) tick();
        tick();
`ifdef CASCADE_TIMEOUT_EN
        chk("t7.abort", 8'(ack_abort), 8'd1);
        chk("t7.cas_out", 8'(cascade_out), 8'd0);
        tick();
        chk("t7.abort_off", 8'(ack_abort), 8'd0);
`else
        chk("t7.no_abort", 8'(ack_abort), 8'd0);
        chk("t7.cas_held", 8'(cascade_out), 8'd5);
        do_train(2, 3, 3'b111, "t7");
`endif
        inta_n = 1'b0;
        tick();
        tick();
        inta_n = 1'b1;
        tick();
        repeat (TO - 1) tick();
        do_train(2, 3, 3'b111, "t8");

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
